// File: rtl/reg_file_mp_pkg.sv
// Shared definitions for the multi-port register file: load tracker states and
// the default parameter constants used by reg_file_mp and its tracker.
package reg_file_mp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } ld_state_e;

    localparam int DEF_DW    = 8;
    localparam int DEF_NREG  = 16;
    localparam int DEF_PTR_W = 12;

endpackage

// File: rtl/reg_file_ld_track.sv
// Single-outstanding load tracker: remembers which register the in-flight load
// will write and arbitrates issue/return handshakes.
module reg_file_ld_track
    import reg_file_mp_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_dest,
    input  logic          wb_valid,
    output logic [AW-1:0] pdest,
    output logic          pend,
    output logic          ld_ready,
    output logic          wb_ready
);

    ld_state_e     state_q;
    logic [AW-1:0] pdest_q;

    // A new load can only be accepted while pending if the current one returns
    // in the same cycle, so the tracker never holds more than one destination.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pdest_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_valid) begin
                        pdest_q <= ld_dest;
                        state_q <= PEND;
                    end
                end
                PEND: begin
                    if (wb_valid) begin
                        if (ld_valid) begin
                            pdest_q <= ld_dest;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pend     = (state_q == PEND);
    assign pdest    = pdest_q;
    assign ld_ready = !pend || wb_valid;
    assign wb_ready = pend;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with load writeback, literal and ALU write ports,
// an auto-incrementing pointer register pair and same-cycle read bypass.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter  int DW      = DEF_DW,
    parameter  int NREG    = DEF_NREG,
    parameter  int LIT_REG = NREG - 2,
    parameter  int PTR_LO  = NREG - 4,
    parameter  int PTR_W   = DEF_PTR_W,
    localparam int AW      = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [DW-1:0]    wd,
    input  logic             lit_we,
    input  logic [DW-1:0]    lit,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_dest,
    output logic             ld_ready,
    input  logic             wb_valid,
    input  logic [DW-1:0]    wb_data,
    output logic             wb_ready,
    input  logic             ptr_inc,
    output logic [PTR_W-1:0] ptr_addr,
    input  logic [AW-1:0]    sa,
    input  logic [AW-1:0]    sb,
    output logic [DW-1:0]    a,
    output logic [DW-1:0]    b,
    output logic             stall
);

    localparam int            PW2        = 2 * DW;
    localparam logic [AW-1:0] LIT_IDX    = AW'(LIT_REG);
    localparam logic [AW-1:0] PTR_LO_IDX = AW'(PTR_LO);
    localparam logic [AW-1:0] PTR_HI_IDX = AW'(PTR_LO + 1);

    logic [DW-1:0]    rf_q [NREG];
    logic [DW-1:0]    rf_d [NREG];
    logic [AW-1:0]    pdest;
    logic             pend;
    logic             wbFire;
    logic [PTR_W-1:0] ptrCur;
    logic [PTR_W-1:0] ptrNext;
    logic [PW2-1:0]   ptrNextFull;

    reg_file_ld_track #(
        .AW(AW)
    ) u_ld_track (
        .clk      (clk),
        .reset    (reset),
        .ld_valid (ld_valid),
        .ld_dest  (ld_dest),
        .wb_valid (wb_valid),
        .pdest    (pdest),
        .pend     (pend),
        .ld_ready (ld_ready),
        .wb_ready (wb_ready)
    );

    assign wbFire = pend && wb_valid;

    // Widening the truncated pointer back to the pair clears the unused high bits.
    assign ptrCur      = PTR_W'({rf_q[PTR_HI_IDX], rf_q[PTR_LO_IDX]});
    assign ptrNext     = ptrCur + PTR_W'(1);
    assign ptrNextFull = PW2'(ptrNext);

    // Writes are applied lowest priority first so each later one overrides.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (ptr_inc) begin
            rf_d[PTR_LO_IDX] = ptrNextFull[DW-1:0];
            rf_d[PTR_HI_IDX] = ptrNextFull[PW2-1:DW];
        end
        if (we) begin
            rf_d[wa] = wd;
        end
        if (lit_we) begin
            rf_d[LIT_IDX] = lit;
        end
        if (wbFire) begin
            rf_d[pdest] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Reads see the post-arbitration value; forced to zero while held in reset.
    assign a        = reset ? '0 : rf_d[sa];
    assign b        = reset ? '0 : rf_d[sb];
    assign ptr_addr = ptrCur;
    assign stall    = pend && !wb_valid && ((sa == pdest) || (sb == pdest));

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios with literal
// expectations, then randomized traffic compared against a behavioural model.
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic        we;
    logic [3:0]  wa;
    logic [7:0]  wd;
    logic        litWe;
    logic [7:0]  lit;
    logic        ldValid;
    logic [3:0]  ldDest;
    logic        ldReady;
    logic        wbValid;
    logic [7:0]  wbData;
    logic        wbReady;
    logic        ptrInc;
    logic [11:0] ptrAddr;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        stall;

    int checkCount = 0;
    int failCount  = 0;
    bit checkEn    = 0;

    logic [7:0] mem [16];
    logic [7:0] nxt [16];
    bit         mPend;
    int         mPdest;

    reg_file_mp dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .lit_we   (litWe),
        .lit      (lit),
        .ld_valid (ldValid),
        .ld_dest  (ldDest),
        .ld_ready (ldReady),
        .wb_valid (wbValid),
        .wb_data  (wbData),
        .wb_ready (wbReady),
        .ptr_inc  (ptrInc),
        .ptr_addr (ptrAddr),
        .sa       (sa),
        .sb       (sb),
        .a        (a),
        .b        (b),
        .stall    (stall)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Pointer value as plain arithmetic on the two stored bytes.
    function automatic int ptrVal();
        return (int'(mem[13]) * 256 + int'(mem[12])) % 4096;
    endfunction

    // What register idx holds after this cycle's edge, by write priority.
    function automatic logic [7:0] expReg(input int idx);
        int p;
        p = (ptrVal() + 1) % 4096;
        if (mPend && wbValid && idx == mPdest) return wbData;
        if (litWe && idx == 14) return lit;
        if (we && idx == int'(wa)) return wd;
        if (ptrInc && idx == 12) return 8'(p % 256);
        if (ptrInc && idx == 13) return 8'(p / 256);
        return mem[idx];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mPend  = 0;
        mPdest = 0;
    endtask

    task automatic modelStep();
        for (int i = 0; i < 16; i++) nxt[i] = expReg(i);
        for (int i = 0; i < 16; i++) mem[i] = nxt[i];
        if (!mPend) begin
            if (ldValid) begin
                mPend  = 1;
                mPdest = int'(ldDest);
            end
        end else if (wbValid) begin
            if (ldValid) mPdest = int'(ldDest);
            else         mPend  = 0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) modelReset();
        else       modelStep();
    end

    task automatic compareAll();
        if (reset) begin
            checkOutput("m_a", 16'(a), 16'h0);
            checkOutput("m_b", 16'(b), 16'h0);
            checkOutput("m_ptr", 16'(ptrAddr), 16'h0);
            checkOutput("m_stall", 16'(stall), 16'h0);
            checkOutput("m_ldready", 16'(ldReady), 16'h1);
            checkOutput("m_wbready", 16'(wbReady), 16'h0);
        end else begin
            checkOutput("m_a", 16'(a), 16'(expReg(int'(sa))));
            checkOutput("m_b", 16'(b), 16'(expReg(int'(sb))));
            checkOutput("m_ptr", 16'(ptrAddr), 16'(ptrVal()));
            checkOutput("m_stall", 16'(stall),
                        16'(mPend && !wbValid && (int'(sa) == mPdest || int'(sb) == mPdest)));
            checkOutput("m_ldready", 16'(ldReady), 16'(!mPend || wbValid));
            checkOutput("m_wbready", 16'(wbReady), 16'(mPend));
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) compareAll();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic weV, input logic [3:0] waV, input logic [7:0] wdV,
                                 input logic litWeV, input logic [7:0] litV,
                                 input logic ldValidV, input logic [3:0] ldDestV,
                                 input logic wbValidV, input logic [7:0] wbDataV,
                                 input logic ptrIncV, input logic [3:0] saV, input logic [3:0] sbV);
        we      = weV;
        wa      = waV;
        wd      = wdV;
        litWe   = litWeV;
        lit     = litV;
        ldValid = ldValidV;
        ldDest  = ldDestV;
        wbValid = wbValidV;
        wbData  = wbDataV;
        ptrInc  = ptrIncV;
        sa      = saV;
        sb      = sbV;
    endtask

    initial begin
        reset = 1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        modelReset();
        checkEn = 1;

        // Outputs while held in reset, with noise on the inputs.
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'hEE, 1, 3, 12); #2;
        checkOutput("rst_a", 16'(a), 16'h0);
        checkOutput("rst_ldready", 16'(ldReady), 16'h1);
        checkOutput("rst_wbready", 16'(wbReady), 16'h0);
        checkOutput("rst_stall", 16'(stall), 16'h0);
        checkOutput("rst_ptr", 16'(ptrAddr), 16'h0);
        tick; reset = 0;

        // ALU write with bypass, then stored value.
        applyStimulus(1, 3, 8'h5A, 0, 0, 0, 0, 0, 0, 0, 3, 0); #2;
        checkOutput("bypass_a", 16'(a), 16'h5A);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0); #2;
        checkOutput("write_a", 16'(a), 16'h5A);

        // Pointer wrap from FFF.
        tick; applyStimulus(1, 12, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick; applyStimulus(1, 13, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 13, 0);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 12); #2;
        checkOutput("ptr_full", 16'(ptrAddr), 16'hFFF);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 12); #2;
        checkOutput("ptr_wrap", 16'(ptrAddr), 16'h000);
        checkOutput("ptr_hi", 16'(a), 16'h00);
        checkOutput("ptr_lo", 16'(b), 16'h00);

        // Load to R5 stalls reads of R5 until data returns.
        tick; applyStimulus(0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0); #2;
            checkOutput("ld_stall", 16'(stall), 16'h1);
        end
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'hC3, 0, 5, 0); #2;
        checkOutput("wb_nostall", 16'(stall), 16'h0);
        checkOutput("wb_bypass", 16'(a), 16'hC3);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0); #2;
        checkOutput("wb_a", 16'(a), 16'hC3);
        checkOutput("wb_idle", 16'(wbReady), 16'h0);

        // Writeback beats literal and ALU on R14.
        tick; applyStimulus(0, 0, 0, 0, 0, 1, 14, 0, 0, 0, 0, 0);
        tick; applyStimulus(1, 14, 8'h22, 1, 8'h11, 0, 0, 1, 8'h77, 0, 14, 0); #2;
        checkOutput("prio_bypass", 16'(a), 16'h77);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14, 0); #2;
        checkOutput("prio_a", 16'(a), 16'h77);

        // Back-to-back load: return to R9 while issuing to R2.
        tick; applyStimulus(0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        tick; applyStimulus(0, 0, 0, 0, 0, 1, 2, 1, 8'h3C, 0, 9, 0); #2;
        checkOutput("b2b_ldready", 16'(ldReady), 16'h1);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 2); #2;
        checkOutput("b2b_a", 16'(a), 16'h3C);
        checkOutput("b2b_pend", 16'(wbReady), 16'h1);
        checkOutput("b2b_stall", 16'(stall), 16'h1);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'h99, 0, 2, 0);
        tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0); #2;
        checkOutput("b2b_second", 16'(a), 16'h99);
        checkOutput("b2b_idle", 16'(wbReady), 16'h0);

        // Reset discards a pending load.
        tick; applyStimulus(0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
        tick; reset = 1; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #2;
        checkOutput("rstp_ldready", 16'(ldReady), 16'h1);
        checkOutput("rstp_wbready", 16'(wbReady), 16'h0);
        tick; reset = 0; applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 8'hAA, 0, 7, 0); #2;
        checkOutput("rstp_wbign", 16'(wbReady), 16'h0);
        checkOutput("rstp_a", 16'(a), 16'h00);
        for (int i = 0; i < 16; i++) begin
            tick; applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(i), 4'(15 - i)); #2;
            checkOutput("rstp_clear_a", 16'(a), 16'h00);
            checkOutput("rstp_clear_b", 16'(b), 16'h00);
        end

        // Randomized traffic, checked by the model on every cycle.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] wdR;
            tick;
            reset = ($urandom_range(0, 299) == 0);
            wdR = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
            applyStimulus($urandom_range(0, 1) == 1, 4'($urandom), wdR,
                          $urandom_range(0, 3) == 0, 8'($urandom),
                          $urandom_range(0, 2) == 0, 4'($urandom),
                          $urandom_range(0, 4) < 2, 8'($urandom),
                          $urandom_range(0, 3) == 0, 4'($urandom), 4'($urandom));
        end
        tick; reset = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        checkEn = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL have parameter DW, default 8: register data width.
REQ-002 SHALL have parameter NREG, default 16, power of two >= 4: register count; AW = log2(NREG).
REQ-003 SHALL have parameter LIT_REG, default NREG-2: literal-load target register.
REQ-004 SHALL have parameter PTR_LO, default NREG-4, even: pointer pair low register; high register is PTR_LO+1.
REQ-005 SHALL have parameter PTR_W, default 12, DW < PTR_W <= 2*DW: pointer address width.
REQ-006 SHALL have ports: clk in 1 clock; reset in 1 reset, asynchronous, active-high.
REQ-007 SHALL have ports: we in 1 ALU write enable; wa in AW ALU write index; wd in DW ALU write data.
REQ-008 SHALL have ports: lit_we in 1 literal write enable; lit in DW literal value.
REQ-009 SHALL have ports: ld_valid in 1 load issue; ld_dest in AW load destination; ld_ready out 1 load accepted.
REQ-010 SHALL have ports: wb_valid in 1 load data return; wb_data in DW; wb_ready out 1.
REQ-011 SHALL have ports: ptr_inc in 1 pointer increment; ptr_addr out PTR_W pointer value.
REQ-012 SHALL have ports: sa, sb in AW read indices; a, b out DW read data; stall out 1 read hazard.

Function
REQ-013 SHALL implement a two-state load tracker, IDLE and PEND, holding one pending destination register pdest.
REQ-014 SHALL drive ld_ready = 1 in IDLE, and 1 in PEND only while wb_valid is 1; wb_ready SHALL be 1 only in PEND.
REQ-015 In IDLE, ld_valid SHALL latch pdest = ld_dest and move the tracker to PEND.
REQ-016 In PEND, wb_valid SHALL write wb_data to pdest and return the tracker to IDLE, unless ld_valid is also 1, in which case it SHALL stay in PEND with the new pdest.
REQ-017 In IDLE, wb_valid SHALL be ignored, with no register write.
REQ-018 Per cycle and per register, write priority SHALL be: load writeback > literal (LIT_REG) > ALU write > pointer increment; lower-priority writes to the same register are dropped.
REQ-019 ptr_inc SHALL set the pointer {R[PTR_LO+1], R[PTR_LO]} to (P+1) mod 2^PTR_W, zeroing the unused high-register bits, in one cycle.
REQ-020 ptr_inc SHALL leave a pointer half that is targeted by a higher-priority write taking that write's value; the other half SHALL take the incremented value.
REQ-021 ptr_addr SHALL equal {R[PTR_LO+1], R[PTR_LO]}[PTR_W-1:0], combinationally from the stored registers.
REQ-022 a and b SHALL be combinational reads with same-cycle bypass: if the index matches a winning write in this cycle, the output SHALL show the write data.
REQ-023 stall SHALL be 1 when the tracker is in PEND, (sa == pdest or sb == pdest), and wb_valid is 0.
REQ-024 The tracker SHALL take no action on a write to pdest by another port; the later writeback SHALL overwrite it.
REQ-025 Read latency SHALL be 0 cycles; write latency SHALL be 1 clock edge.

Reset
REQ-026 Asserting reset SHALL immediately clear all registers to 0, set the tracker to IDLE, and clear pdest to 0.
REQ-027 During reset, outputs SHALL be: a = b = 0, ptr_addr = 0, stall = 0, ld_ready = 1, wb_ready = 0.
REQ-028 A load pending when reset is asserted SHALL be discarded; a wb_valid after reset SHALL be ignored.

Structure
REQ-029 The shared package SHALL hold the tracker state enum (IDLE, PEND) and the default parameter constants.
REQ-030 The tracker SHALL be a sub-module, reg_file_ld_track, with outputs pdest, pend, ld_ready and wb_ready.
REQ-031 Register storage, write arbitration, bypass and the pointer increment SHALL stay in reg_file_mp.

Verification
REQ-032 Reset, then we=1, wa=3, wd=8'h5A -> the next cycle a = 8'h5A with sa=3; in the write cycle, sa=3 shows 8'h5A via bypass.
REQ-033 Set the pointer to 12'hFFF, pulse ptr_inc -> ptr_addr = 12'h000 and R[PTR_LO+1] = 8'h00.
REQ-034 ld_valid with dest 5, sa=5, wb_valid held low 3 cycles -> stall = 1 for those 3 cycles; then wb_valid with 8'hC3 -> a = 8'hC3, stall = 0, tracker in IDLE.
REQ-035 In one cycle, wb_valid to pdest 14, lit_we=1 with lit=8'h11, and we to 14 -> R14 = wb_data.
REQ-036 In PEND, wb_valid and ld_valid(dest 2) in the same cycle -> first destination written, tracker stays in PEND with pdest = 2.
REQ-037 Assert reset while in PEND, then wb_valid -> no register write, all registers 0, ld_ready = 1.
